// File: rtl/kmeans_iter_ctrl.sv
// Iteration controller for the k=2, n=2 k-means datapath: runs classification
// passes, reads back sums/counts, divides out new centroids, repeats until stable.
module kmeans_iter_ctrl #(
  parameter int data_width    = 16,
  parameter int acc_sum_width = 24,
  parameter int cnt_width     = 9,
  parameter int max_iter      = 16,
  parameter int iter_width    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic [iter_width-1:0]    iter_count,
  output logic                     kmeans_rst,
  input  logic                     kmeans_rdy,
  output logic                     class_en,
  input  logic                     class_done,
  output logic                     bck_rd,
  output logic                     bck_rd_addr,
  input  logic [acc_sum_width-1:0] sum_d0,
  input  logic [acc_sum_width-1:0] sum_d1,
  input  logic [cnt_width-1:0]     k0_count,
  input  logic [cnt_width-1:0]     k1_count,
  input  logic [data_width-1:0]    k0_0,
  input  logic [data_width-1:0]    k0_1,
  input  logic [data_width-1:0]    k1_0,
  input  logic [data_width-1:0]    k1_1,
  output logic [data_width-1:0]    k0_0_n,
  output logic [data_width-1:0]    k0_1_n,
  output logic [data_width-1:0]    k1_0_n,
  output logic [data_width-1:0]    k1_1_n,
  output logic                     up_centroids,
  output logic [3:0]               fsm_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    KRST     = 4'd1,
    WAIT_RDY = 4'd2,
    CLASS    = 4'd3,
    READ     = 4'd4,
    DIV      = 4'd5,
    UPDATE   = 4'd6,
    CHECK    = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam int bit_w = $clog2(acc_sum_width);
  localparam logic [bit_w-1:0] last_bit = bit_w'(acc_sum_width - 1);

  state_t                   state;
  logic [1:0]               rd_cnt;
  logic [1:0]               div_idx;
  logic                     div_run;
  logic [bit_w-1:0]         bit_cnt;
  logic [acc_sum_width-1:0] sums [4];
  logic [cnt_width-1:0]     cnt0, cnt1;
  logic [acc_sum_width-1:0] quo, quo_nx;
  logic [cnt_width-1:0]     rem, rem_nx;
  logic [cnt_width:0]       rem_shift;
  logic [data_width-1:0]    res [4];
  logic [cnt_width-1:0]     divisor;
  logic [data_width-1:0]    cur;
  logic [data_width-1:0]    res_val;
  logic                     div_fin;
  logic                     all_same;

  assign fsm_state = state;
  assign k0_0_n = res[0];
  assign k0_1_n = res[1];
  assign k1_0_n = res[2];
  assign k1_1_n = res[3];

  // One restoring-division step; a zero divisor finishes in the load cycle
  // and keeps the current centroid.
  always_comb begin
    divisor   = div_idx[1] ? cnt1 : cnt0;
    cur       = k0_0;
    rem_shift = {rem, quo[acc_sum_width-1]};
    rem_nx    = rem_shift[cnt_width-1:0];
    quo_nx    = {quo[acc_sum_width-2:0], 1'b0};
    case (div_idx)
      2'd0: cur = k0_0;
      2'd1: cur = k0_1;
      2'd2: cur = k1_0;
      default: cur = k1_1;
    endcase
    if (rem_shift >= {1'b0, divisor}) begin
      rem_nx = cnt_width'(rem_shift - {1'b0, divisor});
      quo_nx = {quo[acc_sum_width-2:0], 1'b1};
    end
    div_fin = div_run ? (bit_cnt == last_bit) : (divisor == '0);
    res_val = div_run ? quo_nx[data_width-1:0] : cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      iter_count   <= '0;
      kmeans_rst   <= 1'b0;
      class_en     <= 1'b0;
      bck_rd       <= 1'b0;
      bck_rd_addr  <= 1'b0;
      up_centroids <= 1'b0;
      rd_cnt       <= '0;
      div_idx      <= '0;
      div_run      <= 1'b0;
      bit_cnt      <= '0;
      quo          <= '0;
      rem          <= '0;
      cnt0         <= '0;
      cnt1         <= '0;
      all_same     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sums[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iter_count <= '0;
            converged  <= 1'b0;
            busy       <= 1'b1;
            kmeans_rst <= 1'b1;
            state      <= KRST;
          end
        end
        KRST: begin
          kmeans_rst <= 1'b0;
          state      <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (kmeans_rdy) begin
            class_en <= 1'b1;
            state    <= CLASS;
          end
        end
        CLASS: begin
          if (class_done) begin
            class_en    <= 1'b0;
            iter_count  <= iter_count + iter_width'(1);
            bck_rd      <= 1'b1;
            bck_rd_addr <= 1'b0;
            rd_cnt      <= '0;
            state       <= READ;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 2'd1;
          case (rd_cnt)
            2'd0: begin
              sums[0]     <= sum_d0;
              sums[1]     <= sum_d1;
              bck_rd_addr <= 1'b1;
            end
            2'd1: begin
              sums[2] <= sum_d0;
              sums[3] <= sum_d1;
            end
            2'd2: begin
              cnt0 <= k0_count;
              cnt1 <= k1_count;
            end
            default: begin
              bck_rd      <= 1'b0;
              bck_rd_addr <= 1'b0;
              div_idx     <= '0;
              div_run     <= 1'b0;
              state       <= DIV;
            end
          endcase
        end
        DIV: begin
          if (div_fin) begin
            res[div_idx] <= res_val;
            div_run      <= 1'b0;
            div_idx      <= div_idx + 2'd1;
            if (div_idx == 2'd3) begin
              up_centroids <= 1'b1;
              state        <= UPDATE;
            end
          end else if (!div_run) begin
            quo     <= sums[div_idx];
            rem     <= '0;
            bit_cnt <= '0;
            div_run <= 1'b1;
          end else begin
            quo     <= quo_nx;
            rem     <= rem_nx;
            bit_cnt <= bit_cnt + bit_w'(1);
          end
        end
        UPDATE: begin
          // Current centroids are still the pre-update values in this cycle.
          up_centroids <= 1'b0;
          all_same     <= (res[0] == k0_0) && (res[1] == k0_1) &&
                          (res[2] == k1_0) && (res[3] == k1_1);
          state        <= CHECK;
        end
        CHECK: begin
          if (all_same) begin
            converged <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else if (iter_count == iter_width'(max_iter)) begin
            converged <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            kmeans_rst <= 1'b1;
            state      <= KRST;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench for kmeans_iter_ctrl with a small behavioural model of the
// classification datapath (ready delay, class_done pulse, sum memories, centroids).
module tb_kmeans_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, converged;
  logic [4:0]  iter_count;
  logic        kmeans_rst;
  logic        kmeans_rdy = 1'b0;
  logic        class_en;
  logic        class_done = 1'b0;
  logic        bck_rd, bck_rd_addr;
  logic [23:0] sum_d0, sum_d1;
  logic [8:0]  k0_count, k1_count;
  logic [15:0] k0_0, k0_1, k1_0, k1_1;
  logic [15:0] k0_0_n, k0_1_n, k1_0_n, k1_1_n;
  logic        up_centroids;
  logic [3:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // model state
  logic [23:0] sa [4];
  logic [23:0] sb [4];
  logic [8:0]  ca [2];
  logic [8:0]  cb [2];
  logic        alt_mode;
  logic        phase = 1'b0;
  logic        set_req;
  logic [15:0] set_val [4];
  logic [15:0] cent [4];
  int          rdy_wait = 0;
  int          cls_cnt = 0;
  int          rst_cnt = 0;
  int          up_cnt = 0;
  int          done_cnt = 0;
  int          base_rst, base_up, base_done;

  always #5 clk = ~clk;

  kmeans_iter_ctrl #(.max_iter(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count), .kmeans_rst(kmeans_rst),
    .kmeans_rdy(kmeans_rdy), .class_en(class_en), .class_done(class_done),
    .bck_rd(bck_rd), .bck_rd_addr(bck_rd_addr), .sum_d0(sum_d0), .sum_d1(sum_d1),
    .k0_count(k0_count), .k1_count(k1_count), .k0_0(k0_0), .k0_1(k0_1),
    .k1_0(k1_0), .k1_1(k1_1), .k0_0_n(k0_0_n), .k0_1_n(k0_1_n),
    .k1_0_n(k1_0_n), .k1_1_n(k1_1_n), .up_centroids(up_centroids),
    .fsm_state(fsm_state)
  );

  assign k0_0 = cent[0];
  assign k0_1 = cent[1];
  assign k1_0 = cent[2];
  assign k1_1 = cent[3];

  always_comb begin
    sum_d0   = phase ? (bck_rd_addr ? sb[2] : sb[0]) : (bck_rd_addr ? sa[2] : sa[0]);
    sum_d1   = phase ? (bck_rd_addr ? sb[3] : sb[1]) : (bck_rd_addr ? sa[3] : sa[1]);
    k0_count = phase ? cb[0] : ca[0];
    k1_count = phase ? cb[1] : ca[1];
  end

  always @(posedge clk) begin
    if (kmeans_rst) begin
      rst_cnt    <= rst_cnt + 1;
      kmeans_rdy <= 1'b0;
      rdy_wait   <= 2;
      if (alt_mode) phase <= ~phase;
    end else if (rdy_wait != 0) begin
      rdy_wait <= rdy_wait - 1;
      if (rdy_wait == 1) kmeans_rdy <= 1'b1;
    end
    if (!alt_mode) phase <= 1'b0;
    if (class_en && !class_done) begin
      cls_cnt <= cls_cnt + 1;
      if (cls_cnt == 2) class_done <= 1'b1;
    end else begin
      cls_cnt    <= 0;
      class_done <= 1'b0;
    end
    if (set_req) begin
      for (int i = 0; i < 4; i++) cent[i] <= set_val[i];
    end else if (up_centroids) begin
      up_cnt  <= up_cnt + 1;
      cent[0] <= k0_0_n;
      cent[1] <= k0_1_n;
      cent[2] <= k1_0_n;
      cent[3] <= k1_1_n;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_sums_a(input logic [23:0] s00, input logic [23:0] s01,
                            input logic [23:0] s10, input logic [23:0] s11,
                            input logic [8:0] c0, input logic [8:0] c1);
    sa[0] = s00; sa[1] = s01; sa[2] = s10; sa[3] = s11;
    ca[0] = c0;  ca[1] = c1;
  endtask

  task automatic set_cent(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    @(negedge clk);
    set_val[0] = a; set_val[1] = b; set_val[2] = c; set_val[3] = d;
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  task automatic do_start();
    base_rst  = rst_cnt;
    base_up   = up_cnt;
    base_done = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("krst_high", kmeans_rst, 1);
    @(negedge clk);
    check("krst_one_cycle", kmeans_rst, 0);
  endtask

  // sel: 0 done, 1 up_centroids, 2 state CLASS, 3 state DIV
  task automatic wait_for(input string tag, input int sel, input int limit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      case (sel)
        0: found = done;
        1: found = up_centroids;
        2: found = (fsm_state == 4'd3);
        default: found = (fsm_state == 4'd5);
      endcase
    end
    check(tag, found, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_conv"}, converged, 0);
    check({tag, "_iter"}, iter_count, 0);
    check({tag, "_ctl"}, {kmeans_rst, class_en, bck_rd, bck_rd_addr, up_centroids}, 0);
    check({tag, "_kn"}, k0_0_n | k0_1_n | k1_0_n | k1_1_n, 0);
  endtask

  task automatic check_kn(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    check({tag, "_k00"}, k0_0_n, a);
    check({tag, "_k01"}, k0_1_n, b);
    check({tag, "_k10"}, k1_0_n, c);
    check({tag, "_k11"}, k1_1_n, d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alt_mode = 1'b0; set_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_val[i] = '0; sa[i] = '0; sb[i] = '0; cent[i] = '0;
    end
    ca[0] = '0; ca[1] = '0; cb[0] = '0; cb[1] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // basic two-pass convergence
    set_sums_a(24'd10, 24'd20, 24'd300, 24'd400, 9'd2, 9'd4);
    set_cent(16'd0, 16'd0, 16'd0, 16'd0);
    do_start();
    wait_for("t1_up_wait", 1, 400);
    check_kn("t1_pass1", 16'd5, 16'd10, 16'd75, 16'd100);
    check("t1_krst_once", rst_cnt - base_rst, 1);
    check("t1_iter_pass1", iter_count, 1);
    wait_for("t1_done_wait", 0, 400);
    check("t1_converged", converged, 1);
    check("t1_iter", iter_count, 2);
    check("t1_krst_total", rst_cnt - base_rst, 2);
    check("t1_up_total", up_cnt - base_up, 2);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_busy_low", busy, 0);
    check("t1_conv_hold", converged, 1);

    // zero divisor keeps cluster 0
    set_sums_a(24'd50, 24'd60, 24'd9, 24'd9, 9'd0, 9'd3);
    set_cent(16'd7, 16'd9, 16'd1, 16'd1);
    do_start();
    wait_for("t2_up_wait", 1, 400);
    check_kn("t2_pass1", 16'd7, 16'd9, 16'd3, 16'd3);
    wait_for("t2_done_wait", 0, 400);
    check("t2_converged", converged, 1);
    check("t2_iter", iter_count, 2);

    // truncation, plus a start during CLASS that must be ignored
    set_sums_a(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 9'd1, 9'd1);
    set_cent(16'd0, 16'd0, 16'd0, 16'd0);
    do_start();
    wait_for("t3_class_wait", 2, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_class_start_iter", iter_count, 0);
    check("t3_class_start_busy", busy, 1);
    wait_for("t3_up_wait", 1, 400);
    check_kn("t3_trunc", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_for("t3_done_wait", 0, 400);
    check("t3_iter", iter_count, 2);
    check("t3_krst_total", rst_cnt - base_rst, 2);
    check("t3_converged", converged, 1);

    // never converging: sums alternate, limited by max_iter = 3
    set_sums_a(24'd10, 24'd20, 24'd300, 24'd400, 9'd2, 9'd4);
    sb[0] = 24'd20; sb[1] = 24'd40; sb[2] = 24'd600; sb[3] = 24'd800;
    cb[0] = 9'd2; cb[1] = 9'd4;
    alt_mode = 1'b1;
    set_cent(16'd0, 16'd0, 16'd0, 16'd0);
    do_start();
    wait_for("t4_done_wait", 0, 1200);
    check("t4_converged", converged, 0);
    check("t4_iter", iter_count, 3);
    check("t4_krst_total", rst_cnt - base_rst, 3);
    check_kn("t4_final", 16'd10, 16'd20, 16'd150, 16'd200);
    @(negedge clk);
    alt_mode = 1'b0;

    // reset during DIV aborts without done, then a clean run
    set_sums_a(24'd10, 24'd20, 24'd300, 24'd400, 9'd2, 9'd4);
    set_cent(16'd5, 16'd10, 16'd75, 16'd100);
    do_start();
    wait_for("t5_div_wait", 3, 100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_abort");
    @(negedge clk);
    rst = 1'b0;
    base_done = done_cnt;
    repeat (150) @(negedge clk);
    check("t5_no_done", done_cnt - base_done, 0);
    do_start();
    wait_for("t5_done_wait", 0, 400);
    check("t5_converged", converged, 1);
    check("t5_iter", iter_count, 1);
    check("t5_krst_total", rst_cnt - base_rst, 1);
    check_kn("t5_final", 16'd5, 16'd10, 16'd75, 16'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
